instr_fetch_buffer: RTL and testbench
=====================================

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: buffer entries, a power of two, at least 2.
REQ-003 SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port imem_req, output, 1: fetch request valid.
REQ-006 SHALL have port imem_addr, output, 32: fetch address, word aligned.
REQ-007 SHALL have port imem_gnt, input, 1: request accepted when imem_req and imem_gnt are both high.
REQ-008 SHALL have port imem_rvalid, input, 1: response valid; exactly one per accepted request, in order, at least 1 cycle after the grant.
REQ-009 SHALL have port imem_rdata, input, 32: instruction word.
REQ-010 SHALL have port redirect, input, 1: branch, jump or trap redirect pulse.
REQ-011 SHALL have port redirect_pc, input, 32: new fetch target.
REQ-012 SHALL have port id_valid, output, 1: instruction available to decode.
REQ-013 SHALL have port id_ready, input, 1: decode accepts; transfer occurs when id_valid and id_ready are both high.
REQ-014 SHALL have port id_instr, output, 32: instruction to decode.
REQ-015 SHALL have port id_pc, output, 32: PC of id_instr.
REQ-016 SHALL have port id_opcode, output, 7: id_instr[6:0], feeding the immediate-select stage.

Function
REQ-017 SHALL use FSM states FETCH and DRAIN.
REQ-018 SHALL drive imem_req = (state==FETCH) && !redirect && (count + outstanding < DEPTH); imem_addr SHALL equal fetch_pc.
REQ-019 SHALL increment fetch_pc by 4 on each accepted request, wrapping modulo 2^32, so 32'hFFFF_FFFC is followed by 0.
REQ-020 SHALL keep a resp_pc register that advances by 4 per kept response; each buffered entry SHALL store {resp_pc, imem_rdata}.
REQ-021 SHALL drive id_valid high whenever count>0, with id_instr and id_pc taken from the head entry; when id_valid is low, id_instr and id_pc SHALL be 0.
REQ-022 SHALL, on a simultaneous push and pop, change neither count nor ordering; the buffer SHALL NOT overflow, which REQ-018 guarantees.
REQ-023 SHALL, on redirect in any state, take priority over every other event in that cycle:
 - empty the buffer;
 - set fetch_pc and resp_pc to {redirect_pc[31:2],2'b00};
 - discard any same-cycle response;
 - set discard count = outstanding after this cycle;
 - next state = DRAIN if discard count>0, else FETCH.
REQ-024 SHALL, in DRAIN, issue no requests, drop each response and decrement the discard count; it SHALL go to FETCH in the cycle after the last dropped response.
REQ-025 SHALL NOT let a pending pop in the redirect cycle dequeue anything.
REQ-026 SHALL, while id_valid is high and id_ready is low, hold id_instr and id_pc stable.
REQ-027 SHALL have a fetch-to-decode latency of 1 cycle from imem_rvalid to id_valid, except as in REQ-032.

Reset
REQ-028 SHALL, on reset_n low, asynchronously set: state=FETCH, fetch_pc=resp_pc=RESET_PC, count=outstanding=discard=0.
REQ-029 SHALL hold imem_req=0, id_valid=0, id_instr=0 and id_pc=0 while reset_n is low.
REQ-030 SHALL lose all in-flight and buffered state on reset mid-operation; responses arriving after release for pre-reset grants are outside the contract.

Configuration
REQ-031 SHALL provide macro FETCH_BYPASS_EN.
REQ-032 SHALL, with FETCH_BYPASS_EN defined, forward a response combinationally when the buffer is empty, state=FETCH and there is no redirect:
 - id_valid=1, id_instr=imem_rdata, id_pc=resp_pc in the same cycle;
 - if id_ready is also high, the entry SHALL NOT be written to the buffer.
REQ-033 SHALL, without FETCH_BYPASS_EN, always write responses to the buffer first, giving 1-cycle latency.

Structure
REQ-034 SHALL place the FSM state encodings, NOP constant 32'h0000_0013 and the PC increment 4 in the shared constants package.
REQ-035 SHALL implement the storage as sub-module fetch_fifo: DEPTH entries of 64 bits, with push, pop, flush, count, full and empty.

Verification
REQ-036 SHALL cover reset then continuous grant (1-cycle rvalid), id_ready=1: addresses 0,4,8,... and id_pc 0,4,8 in order, without bypass 1 cycle after each rvalid.
REQ-037 SHALL cover id_ready=0 for 10 cycles: at most DEPTH requests are granted, imem_req falls, and id_instr stays stable.
REQ-038 SHALL cover redirect to 32'h0000_1003 with 2 outstanding responses: both are dropped in DRAIN, the next imem_addr is 32'h0000_1000, and the first id_pc is 32'h0000_1000.
REQ-039 SHALL cover redirect coinciding with rvalid and an id handshake: the buffer empties and that data never appears on id_instr.
REQ-040 SHALL cover fetch_pc at 32'hFFFF_FFFC: the next request address is 32'h0000_0000.
REQ-041 SHALL cover FETCH_BYPASS_EN with the buffer empty: id_valid in the same cycle as rvalid, id_opcode equal to imem_rdata[6:0], and count remaining 0.

Source files
------------

// File: rtl/instr_fetch_buffer_pkg.sv
// Shared constants and types for the instruction fetch buffer.
//   fetch_state_t : fetch FSM state encodings
//   NOP_INSTR     : canonical no-op instruction word (addi x0,x0,0)
//   PC_INC        : fetch address step per instruction word
//   fetch_entry_t : one buffered entry, {pc, instr}
//   align_pc      : clears the byte-offset bits of a target address
package instr_fetch_buffer_pkg;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] PC_INC    = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// fetch_fifo: DEPTH-entry, 64-bit wide synchronous FIFO holding fetched
// {pc, instr} pairs.
//   clock, reset_n : clock, async active-low reset
//   push / wdata   : write one entry (accepted when not full, or when a pop
//                    happens in the same cycle)
//   pop  / rdata   : remove head entry; rdata always shows the head
//   flush          : discard all entries; wins over push and pop
//   count, full, empty : occupancy status
module fetch_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [63:0]                wdata,
   output logic [63:0]                rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count gates every read of it.
   always_ff @(posedge clock) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: issues word fetches to instruction memory, buffers the
// returned words with their PCs and hands them to decode in order. A redirect
// flushes everything and drops responses still in flight.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : a response arriving while the buffer is empty (and not being
//               redirected/drained) is shown to decode in the same cycle.
//   undefined : every response is buffered first (1-cycle latency).
//
// Ports
//   clock, reset_n          : clock, async active-low reset
//   imem_req/addr/gnt       : fetch request handshake, word-aligned address
//   imem_rvalid/rdata       : in-order fetch responses, one per grant
//   redirect/redirect_pc    : branch/jump/trap pulse and its target
//   id_valid/ready          : decode handshake
//   id_instr/pc/opcode      : instruction, its PC and its opcode field
//
// state | meaning
// FETCH | normal operation: request while room, keep responses
// DRAIN | after redirect: no requests, drop responses of old stream
module instr_fetch_buffer
   import instr_fetch_buffer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [6:0]  id_opcode
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   fetch_state_t  state_nxt;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] disc_after;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occupancy;
   logic          fifo_full;
   logic          fifo_empty;
   logic [63:0]   head_raw;
   fetch_entry_t  head;
   logic          req_fire;
   logic          keep_resp;
   logic          bypass_hit;
   logic          bypass_take;
   logic          push;
   logic          pop;

   assign occupancy  = {1'b0, fifo_count} + {1'b0, outstanding};
   assign req_fire   = imem_req && imem_gnt;
   assign keep_resp  = imem_rvalid && (state == FETCH) && !redirect;
   // Responses still in flight once this cycle's response (if any) is gone.
   assign disc_after = imem_rvalid ? (outstanding - CW'(1)) : outstanding;
   assign head       = head_raw;

`ifdef FETCH_BYPASS_EN
   assign bypass_hit = keep_resp && fifo_empty;
`else
   assign bypass_hit = 1'b0;
`endif
   assign bypass_take = bypass_hit && id_ready;
   assign push        = keep_resp && !bypass_take;
   // A redirect flushes; the head presented that cycle is not consumed.
   assign pop         = id_ready && !fifo_empty && !redirect;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect),
      .wdata   ({resp_pc, imem_rdata}),
      .rdata   (head_raw),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= FETCH;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (redirect) begin
         state_nxt = (disc_after != '0) ? DRAIN : FETCH;
      end else if (state == DRAIN && imem_rvalid && discard == CW'(1)) begin
         state_nxt = FETCH;
      end
   end

   // Full already implies occupancy >= DEPTH; the extra term is a cheap guard.
   always_comb begin
      imem_req = 1'b0;
      if (reset_n && state == FETCH && !redirect && !fifo_full &&
          occupancy < (CW+1)'(DEPTH)) begin
         imem_req = 1'b1;
      end
   end

   assign imem_addr = fetch_pc;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         case ({req_fire, imem_rvalid})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
         if (redirect) begin
            fetch_pc <= align_pc(redirect_pc);
            resp_pc  <= align_pc(redirect_pc);
            discard  <= disc_after;
         end else begin
            if (req_fire)  fetch_pc <= fetch_pc + PC_INC;
            if (keep_resp) resp_pc  <= resp_pc + PC_INC;
            if (state == DRAIN && imem_rvalid) discard <= discard - CW'(1);
         end
      end
   end

   always_comb begin
      id_valid = 1'b0;
      id_instr = '0;
      id_pc    = '0;
      if (reset_n) begin
         if (!fifo_empty) begin
            id_valid = 1'b1;
            id_instr = head.instr;
            id_pc    = head.pc;
         end else if (bypass_hit) begin
            id_valid = 1'b1;
            id_instr = imem_rdata;
            id_pc    = resp_pc;
         end
      end
   end

   assign id_opcode = id_instr[6:0];

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [6:0]  id_opcode;

   always #5 clock = ~clock;

   instr_fetch_buffer #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_opcode   (id_opcode)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } resp_t;

   // Reference model: exp_q = PCs granted since the last redirect and not yet
   // consumed by decode, oldest first; resp_q = every grant still awaiting
   // its memory response; avail = responses kept but not consumed.
   logic [31:0] exp_q[$];
   resp_t       resp_q[$];
   logic [31:0] model_pc = RESET_PC;
   int          avail = 0;
   int          drain_left = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          lat_min = 1;
   int          lat_max = 1;
   int          timeouts = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   bit          end_req = 1'b0;
   bit          end_done = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_pc = '0;
   logic [31:0] prev_instr = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endfunction

   // Monitor / scoreboard: samples mid-cycle, compares DUT against the model,
   // then advances the model by what happens at the coming clock edge.
   always @(negedge clock) begin
      logic        exp_req;
      logic        kept;
      logic        exp_valid;
      logic        hs;
      logic        grant;
      logic [31:0] hpc;
      logic [31:0] w;
      int          due;
      if (!reset_n) begin
         chk("rst_imem_req", 32'(imem_req), 32'd0);
         chk("rst_id_valid", 32'(id_valid), 32'd0);
         chk("rst_id_instr", id_instr, 32'd0);
         chk("rst_id_pc", id_pc, 32'd0);
         exp_q.delete();
         resp_q.delete();
         avail      = 0;
         drain_left = 0;
         last_due   = 0;
         model_pc   = RESET_PC;
         prev_hold  = 1'b0;
      end else begin
         exp_req   = !redirect && drain_left == 0 && exp_q.size() < DEPTH;
         kept      = imem_rvalid && !redirect && drain_left == 0;
         exp_valid = (avail > 0) || (BYP && kept);
         grant     = imem_req && imem_gnt;
         chk("imem_req", 32'(imem_req), 32'(exp_req));
         chk("id_valid", 32'(id_valid), 32'(exp_valid));
         if (exp_valid) begin
            hpc = (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF;
            w   = mem_word(hpc);
            chk("id_pc", id_pc, hpc);
            chk("id_instr", id_instr, w);
            chk("id_opcode", 32'(id_opcode), 32'(w[6:0]));
         end else begin
            chk("idle_id_pc", id_pc, 32'd0);
            chk("idle_id_instr", id_instr, 32'd0);
         end
         if (prev_hold) begin
            chk("hold_pc", id_pc, prev_pc);
            chk("hold_instr", id_instr, prev_instr);
         end
         if (grant) chk("imem_addr", imem_addr, model_pc);

         if (imem_rvalid && resp_q.size() > 0) void'(resp_q.pop_front());
         if (imem_rvalid && drain_left > 0) drain_left--;
         if (redirect) begin
            exp_q.delete();
            avail      = 0;
            model_pc   = {redirect_pc[31:2], 2'b00};
            drain_left = resp_q.size();
            prev_hold  = 1'b0;
         end else begin
            hs = exp_valid && id_ready;
            if (hs && exp_q.size() > 0) void'(exp_q.pop_front());
            avail = avail + int'(kept) - int'(hs);
            if (grant) begin
               exp_q.push_back(model_pc);
               due = cyc + int'($urandom_range(32'(lat_max), 32'(lat_min)));
               if (due <= last_due) due = last_due + 1;
               last_due = due;
               resp_q.push_back('{model_pc, due});
               model_pc = model_pc + 32'd4;
            end
            prev_hold  = id_valid && !id_ready;
            prev_pc    = id_pc;
            prev_instr = id_instr;
         end
         if (end_req && !end_done) begin
            chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
            chk("end_resp_q_empty", 32'(resp_q.size()), 32'd0);
            chk("wait_timeouts", 32'(timeouts), 32'd0);
            end_done = 1'b1;
         end
      end
      cyc++;
   end

   // rmode: 0 no redirect, 1 redirect now, 2 redirect when exactly two
   // responses are in flight and none returns this cycle, 3 redirect when a
   // response returns this cycle.
   task automatic drive(input bit g, input bit r, input int rmode,
                        input logic [31:0] tgt, output bit fired);
      @(posedge clock);
      #1;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(resp_q[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      case (rmode)
         1:       fired = 1'b1;
         2:       fired = (resp_q.size() == 2) && !imem_rvalid;
         3:       fired = imem_rvalid;
         default: fired = 1'b0;
      endcase
      imem_gnt    = g;
      id_ready    = r;
      redirect    = fired;
      redirect_pc = fired ? tgt : $urandom;
   endtask

   initial begin
      bit fired;
      bit got;
      repeat (3) drive(1'b0, 1'b0, 0, 32'd0, fired);
      reset_n = 1'b1;

      // Streaming after reset: continuous grant, 1-cycle response, ready.
      lat_min = 1; lat_max = 1;
      repeat (20) drive(1'b1, 1'b1, 0, 32'd0, fired);

      // Decode stalled for 10 cycles, then released.
      repeat (10) drive(1'b1, 1'b0, 0, 32'd0, fired);
      repeat (6) drive(1'b1, 1'b1, 0, 32'd0, fired);

      // Redirect to a misaligned target with two responses in flight.
      lat_min = 4; lat_max = 4;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         drive(1'b1, 1'b1, 2, 32'h0000_1003, fired);
         got = fired;
      end
      if (!got) timeouts++;
      repeat (16) drive(1'b1, 1'b1, 0, 32'd0, fired);

      // Redirect coinciding with a response and a decode handshake.
      lat_min = 1; lat_max = 1;
      repeat (6) drive(1'b1, 1'b1, 0, 32'd0, fired);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         drive(1'b1, 1'b1, 3, 32'h0000_2000, fired);
         got = fired;
      end
      if (!got) timeouts++;
      repeat (8) drive(1'b1, 1'b1, 0, 32'd0, fired);

      // Fetch address wrap.
      drive(1'b1, 1'b1, 1, 32'hFFFF_FFFC, fired);
      repeat (10) drive(1'b1, 1'b1, 0, 32'd0, fired);

      // Reset in the middle of traffic.
      lat_min = 1; lat_max = 3;
      repeat (8) drive(1'b1, ($urandom_range(99) < 50), 0, 32'd0, fired);
      reset_n = 1'b0;
      repeat (2) drive(1'b0, 1'b0, 0, 32'd0, fired);
      reset_n = 1'b1;

      // Randomized traffic with occasional redirects.
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 1500; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(99) < 25) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                         : $urandom;
         drive(($urandom_range(99) < 70), ($urandom_range(99) < 60),
               ($urandom_range(99) < 2) ? 1 : 0, tgt, fired);
      end

      // Drain everything still in flight or buffered.
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         drive(1'b0, 1'b1, 0, 32'd0, fired);
         got = (resp_q.size() == 0) && (exp_q.size() == 0);
      end
      if (!got) timeouts++;

      end_req = 1'b1;
      for (int i = 0; i < 5 && !end_done; i++) drive(1'b0, 1'b1, 0, 32'd0, fired);
      if (!end_done) begin
         $display("FAIL end_check: got not-run expected run");
         $fatal(1, "end check never executed");
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
